// File: rtl/freq_counter_multi.sv
// freq_counter_multi: multi-channel gated frequency counter, single-shot or back-to-back windows
//   clk, reset_n (async active-low); enable_i, continuous_i, start_i, gate_len_i control the window
//   sig_i: asynchronous inputs; count_o/overflow_o: last completed window, valid_o pulses on update
//   busy_o: window open; window_id_o: completed windows mod 256
//   FREQCNT_AVG_EN: report the 4-window running average instead of the raw last window
module freq_counter_multi #(
  parameter int NUM_CH      = 4,
  parameter int COUNT_WIDTH = 32,
  parameter int GATE_WIDTH  = 26,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable_i,
  input  logic                          continuous_i,
  input  logic                          start_i,
  input  logic [GATE_WIDTH-1:0]         gate_len_i,
  input  logic [NUM_CH-1:0]             sig_i,
  output logic [NUM_CH*COUNT_WIDTH-1:0] count_o,
  output logic [NUM_CH-1:0]             overflow_o,
  output logic                          valid_o,
  output logic                          busy_o,
  output logic [7:0]                    window_id_o
);
  typedef enum logic {IDLE, GATE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;
  logic [NUM_CH-1:0] prev_q, prev_d, edge_det;
  logic [GATE_WIDTH-1:0] gcnt_q, gcnt_d, glen;
  logic [NUM_CH-1:0][COUNT_WIDTH-1:0] live_q, live_d, sat, count_q, count_d;
  logic [NUM_CH-1:0] ovfl_q, ovfl_d, sovf, ovf_q, ovf_d;
  logic valid_q, valid_d, done;
  logic [7:0] wid_q, wid_d;
`ifdef FREQCNT_AVG_EN
  logic [3:0][NUM_CH-1:0][COUNT_WIDTH-1:0] hist_q, hist_d;
  logic [3:0][NUM_CH-1:0] hovf_q, hovf_d;
  logic [2:0] fill_q, fill_d;
  logic en_q, en_d;
  logic [COUNT_WIDTH+1:0] acc;
`endif
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], sig_i};
    prev_d   = sync_q[SYNC_STAGES-1];
    edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;
    glen     = (gate_len_i == '0) ? GATE_WIDTH'(1) : gate_len_i;
    for (int k = 0; k < NUM_CH; k++) begin
      sat[k]  = (&live_q[k]) ? live_q[k] : live_q[k] + COUNT_WIDTH'(edge_det[k]);
      sovf[k] = ovfl_q[k] | (&live_q[k] & edge_det[k]);
    end
    state_d = state_q;
    gcnt_d  = gcnt_q;
    live_d  = live_q;
    ovfl_d  = ovfl_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    wid_d   = wid_q;
    done    = 1'b0;
    if (state_q == IDLE) begin
      if (enable_i && (continuous_i || start_i)) begin
        state_d = GATE;
        gcnt_d  = glen;
        live_d  = '0;
        ovfl_d  = '0;
      end
    end else if (!enable_i) begin
      state_d = IDLE;
      live_d  = '0;
      ovfl_d  = '0;
    end else if (gcnt_q == GATE_WIDTH'(1)) begin
      done  = 1'b1;
      wid_d = wid_q + 8'd1;
      // back-to-back: next window's first cycle counts its own edge, so nothing is lost or doubled
      if (continuous_i) begin
        gcnt_d = glen;
        live_d = '0;
        ovfl_d = '0;
      end else begin
        state_d = IDLE;
      end
    end else begin
      gcnt_d = gcnt_q - GATE_WIDTH'(1);
      live_d = sat;
      ovfl_d = sovf;
    end
`ifdef FREQCNT_AVG_EN
    hist_d = hist_q;
    hovf_d = hovf_q;
    fill_d = fill_q;
    en_d   = enable_i;
    acc    = '0;
    if (done) begin
      hist_d = {hist_q[2:0], sat};
      hovf_d = {hovf_q[2:0], sovf};
      fill_d = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
      if (fill_q >= 3'd3) begin
        valid_d = 1'b1;
        ovf_d   = hovf_d[0] | hovf_d[1] | hovf_d[2] | hovf_d[3];
        for (int k = 0; k < NUM_CH; k++) begin
          acc = (COUNT_WIDTH+2)'(hist_d[0][k]) + (COUNT_WIDTH+2)'(hist_d[1][k])
              + (COUNT_WIDTH+2)'(hist_d[2][k]) + (COUNT_WIDTH+2)'(hist_d[3][k]);
          count_d[k] = COUNT_WIDTH'(acc >> 2);
        end
      end
    end
    if (en_q && !enable_i) begin
      hist_d = '0;
      hovf_d = '0;
      fill_d = '0;
    end
`else
    if (done) begin
      count_d = sat;
      ovf_d   = sovf;
      valid_d = 1'b1;
    end
`endif
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sync_q  <= '0;
      prev_q  <= '0;
      gcnt_q  <= '0;
      live_q  <= '0;
      ovfl_q  <= '0;
      count_q <= '0;
      ovf_q   <= '0;
      valid_q <= 1'b0;
      wid_q   <= '0;
`ifdef FREQCNT_AVG_EN
      hist_q  <= '0;
      hovf_q  <= '0;
      fill_q  <= '0;
      en_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      gcnt_q  <= gcnt_d;
      live_q  <= live_d;
      ovfl_q  <= ovfl_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      wid_q   <= wid_d;
`ifdef FREQCNT_AVG_EN
      hist_q  <= hist_d;
      hovf_q  <= hovf_d;
      fill_q  <= fill_d;
      en_q    <= en_d;
`endif
    end
  end
  assign count_o     = count_q;
  assign overflow_o  = ovf_q;
  assign valid_o     = valid_q;
  assign busy_o      = (state_q == GATE);
  assign window_id_o = wid_q;
endmodule

// File: tb/tb_freq_counter_multi.sv
// tb_freq_counter_multi: directed table-driven bench for freq_counter_multi
module tb_freq_counter_multi;
  logic clk = 1'b0;
  logic reset_n, enable, cont, start;
  logic [25:0] gl;
  logic [3:0] sig = '0;
  logic [127:0] count1;
  logic [3:0] ovf1;
  logic valid1, busy1;
  logic [7:0] id1;
  logic [3:0] count2;
  logic ovf2, valid2, busy2;
  logic [7:0] id2;
  int checks = 0, failures = 0;
  int per [4] = '{0, 0, 0, 0};
  int ph [4] = '{0, 0, 0, 0};
  int cyc = 0, win_lo = 0, win_hi = -1, model_edges = 0;
  logic [2:0] s_q = '0;
  logic [127:0] cap_cnt, last_cnt;
  logic [3:0] cap_ovf, cap_c2;
  logic cap_o2;
  logic [7:0] cap_id;
  typedef struct packed {
    int gl;
    logic [3:0][7:0] per;
    logic [3:0][31:0] ex;
    logic [3:0] e2;
    logic o2;
  } vec_t;
  vec_t vecs [5];

  freq_counter_multi dut1 (
    .clk(clk), .reset_n(reset_n), .enable_i(enable), .continuous_i(cont), .start_i(start),
    .gate_len_i(gl), .sig_i(sig), .count_o(count1), .overflow_o(ovf1), .valid_o(valid1),
    .busy_o(busy1), .window_id_o(id1));

  freq_counter_multi #(.NUM_CH(1), .COUNT_WIDTH(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .enable_i(enable), .continuous_i(cont), .start_i(start),
    .gate_len_i(gl), .sig_i(sig[0]), .count_o(count2), .overflow_o(ovf2), .valid_o(valid2),
    .busy_o(busy2), .window_id_o(id2));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      sig[k] = (per[k] == 0) ? 1'b0 : (per[k] == 1) ? 1'b1 : (ph[k] < per[k] / 2);
      ph[k]  = (ph[k] + 1 >= per[k]) ? 0 : ph[k] + 1;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    s_q <= {s_q[1:0], sig[0]};
    if (cyc + 1 >= win_lo && cyc + 1 <= win_hi && s_q[1] && !s_q[2]) model_edges <= model_edges + 1;
  end

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  task automatic shot(input int g, output int nv);
    nv = 0;
    gl = 26'(g);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy1, 1);
    for (int i = 0; i < g + 20; i++) begin
      @(negedge clk);
      start = (g >= 20 && i == 5);
      if (valid1) begin
        nv++;
        cap_cnt = count1; cap_ovf = ovf1; cap_c2 = count2; cap_o2 = ovf2; cap_id = id1;
      end
    end
    start = 1'b0;
  endtask

  task automatic set_per(input int a, input int b, input int c, input int d);
    per[0] = a; per[1] = b; per[2] = c; per[3] = d;
    repeat (30) @(negedge clk);
  endtask

  initial begin
    int nv, nc, sum, e0;
    int tv [8];
    int cv [8];
    vecs[0] = '{100, {8'd0, 8'd1, 8'd4, 8'd10}, {32'd0, 32'd0, 32'd25, 32'd10}, 4'd10, 1'b0};
    vecs[1] = '{40, {8'd10, 8'd4, 8'd5, 8'd2}, {32'd4, 32'd10, 32'd8, 32'd20}, 4'd15, 1'b1};
    vecs[2] = '{30, {8'd6, 8'd5, 8'd3, 8'd10}, {32'd5, 32'd6, 32'd10, 32'd3}, 4'd3, 1'b0};
    vecs[3] = '{0, {8'd0, 8'd1, 8'd0, 8'd1}, {32'd0, 32'd0, 32'd0, 32'd0}, 4'd0, 1'b0};
    vecs[4] = '{12, {8'd12, 8'd2, 8'd6, 8'd3}, {32'd1, 32'd6, 32'd2, 32'd4}, 4'd4, 1'b0};
    reset_n = 1'b0; enable = 1'b0; cont = 1'b0; start = 1'b0; gl = '0;
    repeat (3) @(negedge clk);
    chk("rst_count", count1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_id", id1, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_valid", valid1, 0);
    chk("idle_busy", busy1, 0);
    enable = 1'b1;
`ifdef FREQCNT_AVG_EN
    for (int i = 0; i < 4; i++) begin
      set_per(i == 0 ? 10 : i == 1 ? 5 : i == 2 ? 3 : 2, 0, 0, 0);
      shot(i == 2 ? 36 : i == 3 ? 32 : 40, nv);
      chk($sformatf("avg_valid_%0d", i), nv, i == 3 ? 1 : 0);
    end
    chk("avg_count", cap_cnt[31:0], 10);
`else
    for (int v = 0; v < 5; v++) begin
      set_per(vecs[v].per[0], vecs[v].per[1], vecs[v].per[2], vecs[v].per[3]);
      shot(vecs[v].gl, nv);
      chk($sformatf("v%0d_nvalid", v), nv, 1);
      chk($sformatf("v%0d_count", v), cap_cnt, vecs[v].ex);
      chk($sformatf("v%0d_ovf", v), cap_ovf, 0);
      chk($sformatf("v%0d_sat_count", v), cap_c2, vecs[v].e2);
      chk($sformatf("v%0d_sat_ovf", v), cap_o2, vecs[v].o2);
      chk($sformatf("v%0d_id", v), cap_id, v + 1);
      chk($sformatf("v%0d_busy_end", v), busy1, 0);
      last_cnt = vecs[v].ex;
    end
    set_per(10, 4, 1, 0);
    gl = 26'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy1, 0);
    nv = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (valid1) nv++;
    end
    chk("abort_nvalid", nv, 0);
    chk("abort_count", count1, last_cnt);
    chk("abort_id", id1, 5);
    enable = 1'b1;
    set_per(7, 0, 0, 0);
    gl = 26'd100;
    cont = 1'b1;
    e0 = cyc + 1;
    win_lo = cyc + 2;
    win_hi = cyc + 301;
    nc = 0;
    for (int i = 0; i < 420; i++) begin
      @(negedge clk);
      if (i == 350) cont = 1'b0;
      if (valid1 && nc < 8) begin
        tv[nc] = cyc; cv[nc] = int'(count1[31:0]); nc++;
      end
    end
    chk("cont_nvalid", nc, 4);
    chk("cont_first", tv[0], e0 + 100);
    chk("cont_gap1", tv[1] - tv[0], 100);
    chk("cont_gap2", tv[2] - tv[1], 100);
    chk("cont_gap3", tv[3] - tv[2], 100);
    sum = cv[0] + cv[1] + cv[2];
    chk("cont_conserve", sum, model_edges);
    chk("cont_edges_range", (model_edges == 42 || model_edges == 43), 1);
    chk("cont_busy_end", busy1, 0);
    chk("cont_id", id1, 9);
`endif
    set_per(10, 4, 1, 0);
    gl = 26'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mrst_count", count1, 0);
    chk("mrst_ovf", ovf1, 0);
    chk("mrst_valid", valid1, 0);
    chk("mrst_busy", busy1, 0);
    chk("mrst_id", id1, 0);
    chk("mrst_sat_count", count2, 0);
    chk("mrst_sat_busy", busy2, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/freq_counter_multi.md
Name: freq_counter_multi

Overview:
- Parametrised multi-channel gated frequency counter.
- Successor to the single-channel external-clock frequency counter in the OpenADC interface top level.
- Counts rising edges on NUM_CH asynchronous inputs over a programmable gate window, all in one system clock domain. Supports single-shot and back-to-back continuous windows.
- Sits beside usb_interface; the register file reads count_o/overflow_o and drives the control inputs.

Parameters:
- NUM_CH, 4, number of independent input channels (1..16).
- COUNT_WIDTH, 32, edge counter width per channel.
- GATE_WIDTH, 26, width of the gate length register.
- SYNC_STAGES, 2, synchroniser flops per input (>=2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- enable_i  input  1  block enable; low aborts any window.
- continuous_i  input  1  1 = windows repeat back-to-back; 0 = single-shot.
- start_i  input  1  single-shot start request.
- gate_len_i  input  GATE_WIDTH  window length in clk cycles.
- sig_i  input  NUM_CH  asynchronous signals to measure.
- count_o  output  NUM_CH*COUNT_WIDTH  last completed counts; channel k at [k*COUNT_WIDTH +: COUNT_WIDTH].
- overflow_o  output  NUM_CH  per-channel saturation flag for the last completed window.
- valid_o  output  1  one-cycle pulse when count_o/overflow_o update.
- busy_o  output  1  high while a window is open.
- window_id_o  output  8  completed-window counter, modulo 256.

Behaviour:
- Reset (reset_n low, async):
  - All outputs 0. Synchronisers, live counters and the FSM are cleared. State = IDLE.
- Input path:
  - Each sig_i bit passes through SYNC_STAGES flops, then a 1-flop rising-edge detector.
  - Edge latency from sig_i to the count increment is SYNC_STAGES+1 cycles.
  - Pulses shorter than one clk period may be lost. Maximum countable frequency is clk/2.
- FSM states: IDLE, GATE.
- IDLE -> GATE when either:
  - enable_i=1 and start_i=1, or
  - enable_i=1 and continuous_i=1.
- On entry to GATE:
  - Latch gate_len_i; a value of 0 is treated as 1.
  - Load the gate down-counter.
  - Clear the live counters.
  - busy_o=1 from the cycle after entry.
- In GATE:
  - Each cycle, every channel whose edge detector fires increments its live counter.
  - The window is exactly gate_len clk cycles.
- Terminal gate cycle (down-counter == 1):
  - Capture count_o = live + edge for each channel, saturated.
  - Capture overflow_o.
  - Pulse valid_o and increment window_id_o. All of these are registered and visible on the following cycle.
  - If continuous_i=1 and enable_i=1: the next window starts with zero dead time. The live counter reloads with 0 + the edge detected in that cycle's successor. No edge is dropped or double-counted across the boundary. gate_len_i is re-latched.
  - Otherwise: return to IDLE and set busy_o=0.
- Saturation:
  - A live counter stops at all-ones; overflow for that channel sets and holds until the window ends.
  - At the next window start, the live overflow flag clears. overflow_o changes only on valid_o.
- start_i:
  - Ignored while busy_o=1.
  - Ignored when continuous_i=1 (continuous mode self-starts).
- continuous_i deasserted mid-window: the current window completes normally, then the FSM goes to IDLE.
- enable_i low in GATE:
  - Next cycle: state IDLE, busy_o=0, live counters cleared.
  - No valid_o. count_o, overflow_o and window_id_o hold their previous values.
- gate_len_i changes mid-window: no effect until the next window start.

Optional Feature:
- Macro FREQCNT_AVG_EN.
- When defined:
  - Each channel keeps a 4-deep history of completed window counts.
  - count_o reports the sum of the history >> 2, truncated to COUNT_WIDTH.
  - overflow_o is the OR of the 4 history flags.
  - valid_o is suppressed until 4 windows have completed since reset or since the last enable_i rise. After that it pulses every window.
  - The history clears on reset and on enable_i falling.
- When undefined: count_o reports the raw last window; no history storage is synthesised.

Test Plan:
- Single-shot, NUM_CH=4, gate_len=100, start pulse:
  - Stimulus: ch0 period 10 clk, ch1 period 4 clk, ch2 held high, ch3 held low, edges phase-aligned after the window opens.
  - Required: one valid_o; counts ch0=10, ch1=25, ch2=0, ch3=0; window_id_o=1; busy_o=0 afterwards.
- Continuous mode, gate_len=100, ch0 period 7 clk for 350 cycles:
  - Required: valid_o pulses exactly 100 cycles apart.
  - Required: the sum of counts over the first 3 windows equals the edges seen by the detector in those 300 cycles (boundary conservation).
- Saturation, COUNT_WIDTH=4:
  - 20 edges in a window -> count=15, overflow=1.
  - Next window with 3 edges -> count=3, overflow=0.
- Abort: enable_i low at cycle 50 of a 100-cycle window:
  - Required: no valid_o; busy_o=0 next cycle; count_o and window_id_o unchanged.
  - Required: reset_n low mid-window -> all outputs 0 immediately.
- Boundary:
  - gate_len_i=0 -> 1-cycle window, valid_o pulses.
  - start_i while busy is ignored.
  - With FREQCNT_AVG_EN, windows with counts 4, 8, 12, 16 -> first valid_o only after the 4th window, count=10.
